// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake and bus signal of the memory port arbiter: the
// instruction-fetch requester, the data (load/store) requester and the shared
// single-ported memory.
//   slave  : arbiter view (requests and memory completion in, acks/memory out)
//   master : environment view (drives requests and memory completion)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    // data requester
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [3:0]        d_wmask_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              err_o;
    // memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_wmask_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_ack_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
        output d_ack_o, d_rdata_o, err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_rdata_i, mem_ready_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_ack_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
        input  d_ack_o, d_rdata_o, err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch requester
// (read-only) and the data requester (load/store). Accesses are serialised
// through a req/ready memory handshake and completed with one-cycle acks.
// Data has priority over fetch, limited by a streak guard so a waiting fetch
// is never starved; each access can be aborted by a busy-cycle timeout; a
// fetch flush suppresses the ack of the in-flight fetch.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory handshakes)
// Parameters:
//   ADDR_W, DATA_W : address / data widths
//   MAX_D_STREAK   : consecutive data grants allowed while a fetch waits (1..15)
//   TIMEOUT        : busy cycles before abort, 0 disables (1..255)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    // The abort fires in the busy cycle where the counter holds TIMEOUT-1,
    // so mem_req_o is high for exactly TIMEOUT cycles.
    localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT - 1);
    localparam bit         TOUT_EN    = (TIMEOUT != 0);

    state_t            state_r;
    logic [3:0]        streak_r;
    logic [7:0]        tout_cnt_r;
    logic              flush_r;
    logic              owner_d_r;
    logic              if_ack_r;
    logic              d_ack_r;
    logic              err_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [3:0]        mem_wmask_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    logic grant_d_s;
    logic grant_i_s;
    logic timeout_hit_s;
    logic resp_flush_s;
    logic fetch_flushed_s;

    // Arbitration decision, timeout detection and flush gating of the ack cycle.
    always_comb begin
        grant_d_s       = 1'b0;
        grant_i_s       = 1'b0;
        timeout_hit_s   = 1'b0;
        resp_flush_s    = 1'b0;
        fetch_flushed_s = flush_r | bus.if_flush_i;
        if (bus.d_req_i && !((streak_r == STREAK_MAX) && bus.if_req_i)) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = bus.if_req_i;
        end
        if (TOUT_EN && (tout_cnt_r == TOUT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
        // A flush arriving in the fetch ack cycle still cancels that ack.
        if ((state_r == RESP) && !owner_d_r && bus.if_flush_i) begin
            resp_flush_s = 1'b1;
        end else begin
            resp_flush_s = 1'b0;
        end
    end

    // Arbiter FSM with registered memory-side outputs, acks and read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            streak_r    <= 4'd0;
            tout_cnt_r  <= 8'd0;
            flush_r     <= 1'b0;
            owner_d_r   <= 1'b0;
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            err_r       <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wmask_r <= 4'd0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    flush_r <= 1'b0;
                    if (grant_d_s) begin
                        state_r     <= DBUSY;
                        owner_d_r   <= 1'b1;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.d_we_i;
                        mem_addr_r  <= bus.d_addr_i;
                        mem_wdata_r <= bus.d_wdata_i;
                        mem_wmask_r <= bus.d_wmask_i;
                        tout_cnt_r  <= 8'd0;
                        // The streak only counts data grants that overtook a waiting fetch.
                        streak_r    <= bus.if_req_i ? (streak_r + 4'd1) : 4'd0;
                    end else if (grant_i_s) begin
                        state_r     <= IBUSY;
                        owner_d_r   <= 1'b0;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= bus.if_addr_i;
                        mem_wdata_r <= '0;
                        mem_wmask_r <= 4'd0;
                        tout_cnt_r  <= 8'd0;
                        streak_r    <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IBUSY, DBUSY: begin
                    if ((state_r == IBUSY) && bus.if_flush_i) begin
                        flush_r <= 1'b1;
                    end else begin
                        flush_r <= flush_r;
                    end
                    if (bus.mem_ready_i) begin
                        state_r   <= RESP;
                        mem_req_r <= 1'b0;
                        err_r     <= 1'b0;
                        if (owner_d_r) begin
                            d_rdata_r <= bus.mem_rdata_i;
                            d_ack_r   <= 1'b1;
                        end else begin
                            if_rdata_r <= bus.mem_rdata_i;
                            if_ack_r   <= ~fetch_flushed_s;
                        end
                    end else if (timeout_hit_s) begin
                        state_r   <= RESP;
                        mem_req_r <= 1'b0;
                        err_r     <= 1'b1;
                        if (owner_d_r) begin
                            d_rdata_r <= '0;
                            d_ack_r   <= 1'b1;
                        end else begin
                            if_rdata_r <= '0;
                            if_ack_r   <= ~fetch_flushed_s;
                        end
                    end else begin
                        tout_cnt_r <= tout_cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here.
                    state_r  <= IDLE;
                    if_ack_r <= 1'b0;
                    d_ack_r  <= 1'b0;
                    err_r    <= 1'b0;
                    flush_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    if_ack_r  <= 1'b0;
                    d_ack_r   <= 1'b0;
                    err_r     <= 1'b0;
                    flush_r   <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign bus.mem_wmask_o = mem_wmask_r;
    assign bus.if_rdata_o  = if_rdata_r;
    assign bus.d_rdata_o   = d_rdata_r;
    assign bus.d_ack_o     = d_ack_r;
    assign bus.if_ack_o    = if_ack_r & ~resp_flush_s;
    assign bus.err_o       = err_r & ~resp_flush_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(2), .TIMEOUT(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t        sb_if[$];
    exp_t        sb_d[$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_model [logic [31:0]];

    int    errors      = 0;
    int    checks      = 0;
    int    n_if_ack    = 0;
    int    n_d_ack     = 0;
    int    completions = 0;
    int    busy_cycles = 0;
    int    last_busy   = 0;
    int    cur_lat     = 0;
    int    fixed_lat   = 0;
    bit    rand_lat    = 1'b0;
    bit    mem_hang    = 1'b0;
    string grant_log   = "";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // Memory responder: answers each access after a chosen latency, logs the owner
    // of every new access and checks the memory-side fields against the request.
    initial begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_ready_i = 1'b0;
            if (rst || !bus.mem_req_o) begin
                if (busy_cycles != 0) last_busy = busy_cycles;
                busy_cycles = 0;
            end else begin
                busy_cycles++;
                if (busy_cycles == 1) begin
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                    if (bus.mem_addr_o >= 32'h2000) begin
                        grant_log = {grant_log, "D"};
                        chk("mem_we_d", 32'(bus.mem_we_o), 32'(bus.d_we_i));
                        chk("mem_addr_d", bus.mem_addr_o, bus.d_addr_i);
                        if (bus.d_we_i) begin
                            chk("mem_wdata", bus.mem_wdata_o, bus.d_wdata_i);
                            chk("mem_wmask", 32'(bus.mem_wmask_o), 32'(bus.d_wmask_i));
                        end
                    end else begin
                        grant_log = {grant_log, "I"};
                        chk("mem_we_i", 32'(bus.mem_we_o), 32'd0);
                        chk("mem_wmask_i", 32'(bus.mem_wmask_o), 32'd0);
                        chk("mem_addr_i", bus.mem_addr_o, bus.if_addr_i);
                    end
                end
                if (!mem_hang && busy_cycles > cur_lat) begin
                    if (bus.mem_we_o) begin
                        mem_model[bus.mem_addr_o] = merge(mem_rd(bus.mem_addr_o),
                                                          bus.mem_wdata_o, bus.mem_wmask_o);
                        bus.mem_rdata_i = $urandom;
                    end else begin
                        bus.mem_rdata_i = mem_rd(bus.mem_addr_o);
                    end
                    bus.mem_ready_i = 1'b1;
                    completions++;
                end
            end
        end
    end

    // Scoreboard monitor: pops the expected response whenever an ack appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.if_ack_o && bus.d_ack_o) begin
                    checks++; errors++;
                    $display("FAIL dual_ack: both acks high at %0t", $time);
                end
                if (bus.err_o && !bus.if_ack_o && !bus.d_ack_o) begin
                    checks++; errors++;
                    $display("FAIL err_alone: err_o without ack at %0t", $time);
                end
                if (bus.if_ack_o) begin
                    n_if_ack++;
                    if (sb_if.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL if_ack_unexpected: ack with empty queue at %0t", $time);
                    end else begin
                        e = sb_if.pop_front();
                        chk("if_rdata", bus.if_rdata_o, e.data);
                        chk("if_err", 32'(bus.err_o), 32'(e.err));
                    end
                end
                if (bus.d_ack_o) begin
                    n_d_ack++;
                    if (sb_d.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL d_ack_unexpected: ack with empty queue at %0t", $time);
                    end else begin
                        e = sb_d.pop_front();
                        if (e.chk_data) chk("d_rdata", bus.d_rdata_o, e.data);
                        chk("d_err", 32'(bus.err_o), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, output int waited);
        exp_t e;
        e.data = exp; e.err = 1'b0; e.chk_data = 1'b1;
        sb_if.push_back(e);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = addr;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!bus.if_ack_o && waited < 200);
        chk("if_ack_seen", 32'(bus.if_ack_o), 32'd1);
        bus.if_req_i = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] mask, input logic exp_err);
        exp_t e;
        int   n;
        e.data = 32'd0; e.err = exp_err; e.chk_data = 1'b0;
        if (exp_err) begin
            e.chk_data = 1'b1;
        end else if (we) begin
            ref_mem[addr] = merge(ref_rd(addr), wd, mask);
        end else begin
            e.data = ref_rd(addr); e.chk_data = 1'b1;
        end
        sb_d.push_back(e);
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = we;
        bus.d_addr_i  = addr;
        bus.d_wdata_i = wd;
        bus.d_wmask_i = mask;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_ack_o && n < 200);
        chk("d_ack_seen", 32'(bus.d_ack_o), 32'd1);
        bus.d_req_i = 1'b0;
    endtask

    initial begin
        int          w;
        int          a0;
        int          c0;
        int          n;
        logic [31:0] addr;

        rst = 1'b1;
        bus.if_req_i = 1'b0; bus.if_addr_i = 32'd0; bus.if_flush_i = 1'b0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = 32'd0;
        bus.d_wdata_i = 32'd0; bus.d_wmask_i = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_if_ack", 32'(bus.if_ack_o), 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
        chk("rst_d_rdata", bus.d_rdata_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_req", 32'(bus.mem_req_o), 32'd0);

        // T1: single fetch, ready two cycles after mem_req
        mem_model[32'h100] = 32'h0000_0013;
        fixed_lat = 2; grant_log = ""; a0 = n_if_ack;
        do_fetch(32'h100, 32'h0000_0013, w);
        chk("t1_latency", 32'(w), 32'd4);
        repeat (2) @(negedge clk);
        chk("t1_single_ack", 32'(n_if_ack - a0), 32'd1);
        chk_str("t1_grants", grant_log, "I");

        // T2: simultaneous fetch and store -> store first
        fixed_lat = 1; grant_log = "";
        fork
            do_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
            do_fetch(32'h104, init_word(32'h104), w);
        join
        chk_str("t2_order", grant_log, "DI");
        do_data(1'b0, 32'h2000, 32'd0, 4'h0, 1'b0);

        // T3: both held continuously, streak limit 2
        fixed_lat = 0; grant_log = "";
        fork
            begin
                do_fetch(32'h200, init_word(32'h200), w);
                do_fetch(32'h204, init_word(32'h204), w);
            end
            begin
                for (int i = 0; i < 4; i++) do_data(1'b0, 32'h2000 + 32'(i * 4), 32'd0, 4'h0, 1'b0);
            end
        join
        chk_str("t3_order", grant_log, "DDIDDI");

        // T4: memory never ready -> timeout after 8 busy cycles
        mem_hang = 1'b1;
        do_data(1'b0, 32'h2010, 32'd0, 4'h0, 1'b1);
        @(negedge clk);
        chk("t4_busy_cycles", 32'(last_busy), 32'd8);
        chk("t4_d_rdata", bus.d_rdata_o, 32'd0);
        mem_hang = 1'b0;

        // T5: flush during IBUSY suppresses if_ack, access still completes
        fixed_lat = 3; a0 = n_if_ack; c0 = completions;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_req_o && n < 50);
        chk("t5_granted", 32'(bus.mem_req_o), 32'd1);
        bus.if_flush_i = 1'b1; bus.if_req_i = 1'b0;
        @(negedge clk);
        bus.if_flush_i = 1'b0;
        n = 0;
        while (completions == c0 && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("t5_mem_completed", 32'(completions - c0), 32'd1);
        chk("t5_no_if_ack", 32'(n_if_ack - a0), 32'd0);
        do_data(1'b1, 32'h2004, 32'h1234_5678, 4'b0101, 1'b0);
        do_data(1'b0, 32'h2004, 32'd0, 4'h0, 1'b0);

        // Randomised traffic from both requesters against the reference model
        rand_lat = 1'b1;
        fork
            begin
                logic [31:0] fa;
                int          fw;
                repeat (30) begin
                    fa = 32'h400 + 32'($urandom_range(0, 255) * 4);
                    do_fetch(fa, init_word(fa), fw);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                logic [31:0] da;
                repeat (30) begin
                    da = 32'h2000 + 32'($urandom_range(0, 15) * 4);
                    do_data(1'($urandom_range(0, 1)), da, $urandom, 4'($urandom_range(0, 15)), 1'b0);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        rand_lat = 1'b0;

        // T6: reset mid-DBUSY abandons the access asynchronously
        mem_hang = 1'b1; grant_log = ""; a0 = n_d_ack;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h2008;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_cycles < 3 && n < 50);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_mem_req_async", 32'(bus.mem_req_o), 32'd0);
        chk("t6_d_ack", 32'(bus.d_ack_o), 32'd0);
        bus.d_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; mem_hang = 1'b0; fixed_lat = 1;
        chk("t6_no_ack", 32'(n_d_ack - a0), 32'd0);
        addr = 32'h2008;
        do_data(1'b0, addr, 32'd0, 4'h0, 1'b0);
        chk_str("t6_grants", grant_log, "DD");

        repeat (3) @(negedge clk);
        chk("sb_if_empty", 32'(sb_if.size()), 32'd0);
        chk("sb_d_empty", 32'(sb_d.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
